sum_diff_decoder: RTL and testbench

- Inverse of the team's 8-bit-in / 16-bit running-sum accumulator.
- Consumes the accumulator's per-cycle output stream (running sum plus overflow flag) and recovers the original input samples by first-differencing.
- Tracks the accumulator's self-clear after overflow and flags any stream inconsistency.
- Sits on the read side of any link or memory that carries accumulated sums, e.g. a checksum or telemetry path.

---
 rtl/sum_diff_decoder_if.sv | 27 ++
 rtl/sum_diff_decoder.sv | 87 ++++++++
 tb/tb_sum_diff_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sum_diff_decoder_if.sv
// sum_diff_decoder_if: accumulated-sum input stream and decoded-sample output bundle.
interface sum_diff_decoder_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter int CNT_W  = 16
);
    logic              i_valid;
    logic [SUM_W-1:0]  i_sum;
    logic              i_overflow_flag;
    logic              i_restart;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_range_err;
    logic              o_sync_err;
    logic              o_drop;
    logic [CNT_W-1:0]  o_count;

    modport master (
        output i_valid, i_sum, i_overflow_flag, i_restart,
        input  o_valid, o_data, o_range_err, o_sync_err, o_drop, o_count
    );

    modport slave (
        input  i_valid, i_sum, i_overflow_flag, i_restart,
        output o_valid, o_data, o_range_err, o_sync_err, o_drop, o_count
    );
endinterface

// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder: recovers accumulator input samples by first-differencing the running sum,
// tracking the accumulator's post-overflow self-clear and flagging stream inconsistencies.
module sum_diff_decoder #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter int CNT_W  = 16
) (
    input logic               CLK,
    input logic               RST_n,
    sum_diff_decoder_if.slave bus
);
    typedef enum logic {RUN, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  prev_q, prev_d;
    logic [SUM_W-1:0]  diff;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              range_q, range_d;
    logic              sync_q, sync_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= RUN;
            prev_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            range_q <= 1'b0;
            sync_q  <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            range_q <= range_d;
            sync_q  <= sync_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        valid_d = 1'b0;
        data_d  = data_q;
        range_d = 1'b0;
        sync_d  = 1'b0;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
        // Modular subtraction at SUM_W width absorbs the accumulator's carry wrap.
        diff    = bus.i_sum - prev_q;
        if (bus.i_restart) begin
            prev_d  = '0;
            cnt_d   = '0;
            state_d = RUN;
        end else if (bus.i_valid) begin
            if (state_q == RUN) begin
                valid_d = 1'b1;
                data_d  = diff[DATA_W-1:0];
                range_d = |diff[SUM_W-1:DATA_W];
                cnt_d   = cnt_q + CNT_W'(1);
                prev_d  = bus.i_sum;
                state_d = bus.i_overflow_flag ? CLEAR : RUN;
            end else if (bus.i_sum == '0 && !bus.i_overflow_flag) begin
                drop_d  = 1'b1;
                prev_d  = '0;
                state_d = RUN;
            end else begin
                sync_d  = 1'b1;
                prev_d  = bus.i_sum;
                state_d = bus.i_overflow_flag ? CLEAR : RUN;
            end
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_range_err = range_q;
    assign bus.o_sync_err  = sync_q;
    assign bus.o_drop      = drop_q;
    assign bus.o_count     = cnt_q;
endmodule

// File: tb/tb_sum_diff_decoder.sv
// tb_sum_diff_decoder: directed scenarios plus randomized stream, checked every cycle
// against an integer-arithmetic model of the decoding rules.
module tb_sum_diff_decoder;
    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   m_prev = 0, m_cnt = 0, diff = 0, last = 0;
    bit   m_clear = 0;
    int   e_valid = 0, e_data = 0, e_range = 0, e_sync = 0, e_drop = 0;

    always #5 CLK = ~CLK;

    sum_diff_decoder_if bus ();
    sum_diff_decoder dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: each accepted sum yields (sum - previous sum) mod 65536, except the
    // sample following an overflow, which must be a cleared zero and produces no data.
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_prev = 0; m_cnt = 0; m_clear = 0;
            e_valid = 0; e_data = 0; e_range = 0; e_sync = 0; e_drop = 0;
        end else begin
            e_valid = 0; e_range = 0; e_sync = 0; e_drop = 0;
            if (bus.i_restart) begin
                m_prev = 0; m_cnt = 0; m_clear = 0;
            end else if (bus.i_valid) begin
                if (!m_clear) begin
                    diff = (int'(bus.i_sum) - m_prev + 65536) % 65536;
                    e_valid = 1;
                    e_data = diff % 256;
                    e_range = (diff > 255) ? 1 : 0;
                    m_cnt = (m_cnt + 1) % 65536;
                    m_prev = int'(bus.i_sum);
                    m_clear = bus.i_overflow_flag;
                end else if (bus.i_sum == 0 && !bus.i_overflow_flag) begin
                    e_drop = 1; m_prev = 0; m_clear = 0;
                end else begin
                    e_sync = 1; m_prev = int'(bus.i_sum); m_clear = bus.i_overflow_flag;
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("valid", int'(bus.o_valid), e_valid);
        chk("data", int'(bus.o_data), e_data);
        chk("range_err", int'(bus.o_range_err), e_range);
        chk("sync_err", int'(bus.o_sync_err), e_sync);
        chk("drop", int'(bus.o_drop), e_drop);
        chk("count", int'(bus.o_count), m_cnt);
    end

    task automatic step(input bit v, input int sum, input bit ovf, input bit rs);
        bus.i_valid = v;
        bus.i_sum = 16'(sum);
        bus.i_overflow_flag = ovf;
        bus.i_restart = rs;
        @(negedge CLK);
    endtask

    initial begin
        bus.i_valid = 0; bus.i_sum = 0; bus.i_overflow_flag = 0; bus.i_restart = 0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_count", int'(bus.o_count), 0);
        step(1, 5, 0, 0);     chk("lit_d5", int'(bus.o_data), 5);
        step(1, 12, 0, 0);    chk("lit_d7", int'(bus.o_data), 7);
        step(1, 267, 0, 0);   chk("lit_d255", int'(bus.o_data), 255);
        chk("lit_cnt3", int'(bus.o_count), 3);
        chk("lit_norange", int'(bus.o_range_err), 0);
        step(1, 65530, 0, 0);
        step(1, 4, 1, 0);     chk("lit_wrap10", int'(bus.o_data), 10);
        step(1, 0, 0, 0);     chk("lit_drop", int'(bus.o_drop), 1);
        chk("lit_drop_novalid", int'(bus.o_valid), 0);
        step(1, 9, 0, 0);     chk("lit_d9", int'(bus.o_data), 9);
        step(1, 100, 1, 0);
        step(1, 3, 0, 0);     chk("lit_sync", int'(bus.o_sync_err), 1);
        chk("lit_sync_novalid", int'(bus.o_valid), 0);
        step(1, 8, 0, 0);     chk("lit_d5b", int'(bus.o_data), 5);
        step(1, 10, 0, 0);
        step(1, 300, 0, 0);   chk("lit_d22", int'(bus.o_data), 'h22);
        chk("lit_range", int'(bus.o_range_err), 1);
        chk("lit_range_valid", int'(bus.o_valid), 1);
        step(0, 0, 0, 1);
        step(1, 20, 0, 0);    chk("lit_d20", int'(bus.o_data), 20);
        step(0, 0, 0, 0);     chk("lit_gap", int'(bus.o_valid), 0);
        step(0, 0, 0, 0);     chk("lit_gap_hold", int'(bus.o_data), 20);
        step(1, 25, 0, 0);    chk("lit_gap_d5", int'(bus.o_data), 5);
        step(1, 99, 0, 1);    chk("lit_restart_cnt", int'(bus.o_count), 0);
        chk("lit_restart_novalid", int'(bus.o_valid), 0);
        step(1, 7, 0, 0);     chk("lit_d7b", int'(bus.o_data), 7);
        chk("lit_cnt1", int'(bus.o_count), 1);
        step(1, 1000, 0, 0);
        step(1, 1010, 1, 0);
        bus.i_valid = 0; bus.i_overflow_flag = 0;
        #2 RST_n = 1'b0;
        #1;
        chk("async_count", int'(bus.o_count), 0);
        chk("async_data", int'(bus.o_data), 0);
        chk("async_valid", int'(bus.o_valid), 0);
        @(negedge CLK);
        RST_n = 1'b1;
        step(1, 4, 0, 0);     chk("lit_post_rst_d4", int'(bus.o_data), 4);
        chk("lit_post_rst_valid", int'(bus.o_valid), 1);
        last = 4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) last = 0;
            else last = (last + int'($urandom_range(0, 280))) % 65536;
            step($urandom_range(0, 3) != 0, last, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0);
        end
        step(0, 0, 0, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
